csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
Sequencer in front of the machine-mode CSR register file (mstatus/mtvec/mepc/mcause). It accepts CSR instructions, ECALL and MRET from the execute stage, plus a timer interrupt, and arbitrates them onto the single CSR port. It runs the read-then-write steps of CSRRW/CSRRS/CSRRC and drives the one-cycle trap-entry strobe. It also produces the PC redirect for trap entry and MRET.

Parameters:
DATA_LEN, 32, data/PC width; all CSR values and PCs are this width
ECALL_CAUSE, 11, mcause code written on ECALL (M-mode environment call)
IRQ_CAUSE, 7, interrupt code written on timer interrupt; MSB of cause forced to 1

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request from execute stage
req_ready  out  1  request accepted this cycle when req_valid & req_ready
req_op  in  3  0=CSRRW 1=CSRRS 2=CSRRC 3=ECALL 4=MRET; 5-7 illegal, treated as no-op
req_addr  in  12  CSR address
req_src  in  DATA_LEN  rs1/uimm operand
req_pc  in  DATA_LEN  PC of requesting instruction
irq_pending  in  1  level timer interrupt
irq_enable  in  1  global interrupt enable (mstatus.MIE, supplied externally)
irq_pc  in  DATA_LEN  PC to save in mepc on interrupt
resp_valid  out  1  one-cycle pulse: CSR instruction done
resp_rdata  out  DATA_LEN  old CSR value, valid with resp_valid
redirect_valid  out  1  one-cycle pulse: fetch must jump
redirect_pc  out  DATA_LEN  jump target, valid with redirect_valid
busy  out  1  state != IDLE
csr_wen, csr_ren, csr_unusual  out  1 each  CSR file write, read and trap strobes
csr_addr  out  12  CSR file address
csr_wdata, csr_pc, csr_cause  out  DATA_LEN each  CSR file write data, PC for mepc, cause for mcause
csr_rdata, csr_mepc  in  DATA_LEN each  CSR file read data (mtvec while csr_unusual=1) and live mepc

Behaviour:
- States: IDLE, READ, WRITE, TRAP, RET. Request fields (op, addr, src, pc) are registered on accept.
- IDLE priority: irq_take = irq_pending & irq_enable beats any request. On irq_take: req_ready=0, capture irq_pc, cause = {1'b1, IRQ_CAUSE}, go TRAP.
- Otherwise req_ready=1 in IDLE. On accept: op 0-2 -> READ, ECALL -> TRAP with cause ECALL_CAUSE and pc=req_pc, MRET -> RET, illegal -> stay IDLE with no outputs.
- READ (1 cycle): csr_ren=1, csr_addr=addr; capture csr_rdata into old; -> WRITE.
- WRITE (1 cycle): new value by op: RW=src, RS=old|src, RC=old&~src.
  - csr_wen=1 unless op is RS/RC with src==0; then no write.
  - resp_valid=1, resp_rdata=old; -> IDLE.
  - CSR op latency: accept at cycle N, read at N+1, write and response at N+2. Next accept at N+3.
- TRAP (1 cycle): csr_unusual=1, csr_pc=saved pc, csr_cause=saved cause, csr_wen=0, csr_ren=0; redirect_valid=1, redirect_pc=csr_rdata (mtvec); -> IDLE.
- RET (1 cycle): redirect_valid=1, redirect_pc=csr_mepc, no CSR access; -> IDLE.
- Interrupts are sampled only in IDLE. An irq arriving mid-sequence waits until IDLE. If req_valid and irq_take are both high, the irq wins and the request must be held by the requester.
- All csr_* outputs are 0 outside their owning state. Registered operands are never visible on csr_* in IDLE.
- Reset values: state=IDLE; every output 0 except req_ready, which follows the IDLE rule from the first cycle after reset. rst in any state aborts the sequence with no csr_wen/csr_unusual on the following edge.
- Width rules: cause MSB is bit DATA_LEN-1; IRQ_CAUSE and ECALL_CAUSE are zero-extended.

Decomposition:
- Shared package: req_op encodings, state encodings, and the CSR addresses 12'h300/305/341/342 (already used by the CSR file).
- Sub-module csr_alu: combinational RW/RS/RC new-value and write-suppress logic. Everything else stays flat.

Test Plan:
1. CSRRW addr 0x305 src 0x8000_0100, mtvec=0 -> read cycle N+1, csr_wen with wdata 0x8000_0100 at N+2, resp_rdata=0, busy low at N+3.
2. CSRRS 0x300 src 0x8, mstatus=0x1800 -> wdata 0x1808, resp_rdata 0x1800; repeat with src=0 -> no csr_wen, resp_rdata 0x1800.
3. CSRRC 0x300 src 0x1000, mstatus=0x1808 -> wdata 0x0808.
4. ECALL pc 0x8000_0040, mtvec 0x8000_0100 -> TRAP cycle: csr_unusual=1, csr_pc=0x8000_0040, csr_cause=11, redirect_pc=0x8000_0100.
5. irq_pending & irq_enable with req_valid CSRRW in same IDLE cycle -> req_ready=0, cause 0x8000_0007, csr_pc=irq_pc; CSRRW accepted next IDLE. irq_enable=0 -> ignored.
6. MRET with mepc 0x8000_0044 -> redirect_pc 0x8000_0044, no CSR strobes. rst asserted in READ -> IDLE next cycle, no csr_wen ever issued.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared encodings for the machine-mode CSR/trap sequencer: request opcodes,
// sequencer states and the CSR addresses already used by the CSR file.
package csr_trap_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_TRAP  = 3'd3,
        ST_RET   = 3'd4
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

endpackage

// File: rtl/csr_trap_ctrl_alu.sv
// Purpose: new-value and write-suppress logic for CSRRW/CSRRS/CSRRC.
// Latency: combinational.
// Backpressure: none; evaluated whenever the sequencer is in its read step.
module csr_alu
    import csr_trap_ctrl_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic [2:0]          op,
    input  logic [DATA_LEN-1:0] old_val,
    input  logic [DATA_LEN-1:0] src,
    output logic [DATA_LEN-1:0] wdata,
    output logic                wen
);

    // Set/clear with a zero operand is a pure read and must not touch the CSR.
    always_comb begin
        wdata = src;
        wen   = 1'b1;
        case (op)
            OP_CSRRS: begin
                wdata = old_val | src;
                wen   = |src;
            end
            OP_CSRRC: begin
                wdata = old_val & ~src;
                wen   = |src;
            end
            default: begin
                wdata = src;
                wen   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Purpose: arbitrates CSR ops, ECALL, MRET and timer irq onto the single CSR port.
// Latency: CSR op accept N, read N+1, write/resp N+2; trap/ret redirect at N+1.
// Backpressure: req_ready only in IDLE with no irq taken; irq beats a pending request.
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int DATA_LEN    = 32,
    parameter int ECALL_CAUSE = 11,
    parameter int IRQ_CAUSE   = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [11:0]         req_addr,
    input  logic [DATA_LEN-1:0] req_src,
    input  logic [DATA_LEN-1:0] req_pc,
    input  logic                irq_pending,
    input  logic                irq_enable,
    input  logic [DATA_LEN-1:0] irq_pc,
    output logic                resp_valid,
    output logic [DATA_LEN-1:0] resp_rdata,
    output logic                redirect_valid,
    output logic [DATA_LEN-1:0] redirect_pc,
    output logic                busy,
    output logic                csr_wen,
    output logic                csr_ren,
    output logic                csr_unusual,
    output logic [11:0]         csr_addr,
    output logic [DATA_LEN-1:0] csr_wdata,
    output logic [DATA_LEN-1:0] csr_pc,
    output logic [DATA_LEN-1:0] csr_cause,
    input  logic [DATA_LEN-1:0] csr_rdata,
    input  logic [DATA_LEN-1:0] csr_mepc
);

    localparam logic [DATA_LEN-1:0] IRQ_CAUSE_W   = {1'b1, (DATA_LEN-1)'(IRQ_CAUSE)};
    localparam logic [DATA_LEN-1:0] ECALL_CAUSE_W = DATA_LEN'(ECALL_CAUSE);

    state_e              state;
    logic [2:0]          op_q;
    logic [DATA_LEN-1:0] src_q;
    logic [DATA_LEN-1:0] alu_wdata;
    logic                alu_wen;
    logic                irq_take;

    assign irq_take  = irq_pending & irq_enable;
    assign req_ready = (state == ST_IDLE) & ~irq_take;
    assign busy      = (state != ST_IDLE);

    // The CSR file presents mtvec on csr_rdata while csr_unusual is high,
    // so the trap target can only be forwarded combinationally.
    always_comb begin
        redirect_pc = '0;
        case (state)
            ST_TRAP: redirect_pc = csr_rdata;
            ST_RET:  redirect_pc = csr_mepc;
            default: redirect_pc = '0;
        endcase
    end

    csr_alu #(.DATA_LEN(DATA_LEN)) u_alu (
        .op      (op_q),
        .old_val (csr_rdata),
        .src     (src_q),
        .wdata   (alu_wdata),
        .wen     (alu_wen)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            op_q           <= '0;
            src_q          <= '0;
            csr_ren        <= 1'b0;
            csr_wen        <= 1'b0;
            csr_unusual    <= 1'b0;
            csr_addr       <= '0;
            csr_wdata      <= '0;
            csr_pc         <= '0;
            csr_cause      <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            redirect_valid <= 1'b0;
        end else begin
            // Strobes and operands drop back to zero unless the next state owns them.
            csr_ren        <= 1'b0;
            csr_wen        <= 1'b0;
            csr_unusual    <= 1'b0;
            csr_addr       <= '0;
            csr_wdata      <= '0;
            csr_pc         <= '0;
            csr_cause      <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            redirect_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (irq_take) begin
                        csr_pc         <= irq_pc;
                        csr_cause      <= IRQ_CAUSE_W;
                        csr_unusual    <= 1'b1;
                        redirect_valid <= 1'b1;
                        state          <= ST_TRAP;
                    end else if (req_valid) begin
                        case (req_op)
                            OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                                op_q     <= req_op;
                                src_q    <= req_src;
                                csr_addr <= req_addr;
                                csr_ren  <= 1'b1;
                                state    <= ST_READ;
                            end
                            OP_ECALL: begin
                                csr_pc         <= req_pc;
                                csr_cause      <= ECALL_CAUSE_W;
                                csr_unusual    <= 1'b1;
                                redirect_valid <= 1'b1;
                                state          <= ST_TRAP;
                            end
                            OP_MRET: begin
                                redirect_valid <= 1'b1;
                                state          <= ST_RET;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_READ: begin
                    csr_addr   <= csr_addr;
                    csr_wen    <= alu_wen;
                    csr_wdata  <= alu_wen ? alu_wdata : '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= csr_rdata;
                    state      <= ST_WRITE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: a small CSR file model drives csr_rdata/csr_mepc,
// expected output events are queued by the stimulus and matched by a negedge monitor.
module tb_csr_trap_ctrl;
    import csr_trap_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_src, req_pc;
    logic        irq_pending, irq_enable;
    logic [31:0] irq_pc;
    logic        resp_valid, redirect_valid, busy;
    logic [31:0] resp_rdata, redirect_pc;
    logic        csr_wen, csr_ren, csr_unusual;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_pc, csr_cause, csr_rdata, csr_mepc;

    always #5 clk = ~clk;

    csr_trap_ctrl #(.DATA_LEN(32), .ECALL_CAUSE(11), .IRQ_CAUSE(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_src(req_src), .req_pc(req_pc),
        .irq_pending(irq_pending), .irq_enable(irq_enable), .irq_pc(irq_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
        .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_unusual(csr_unusual),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_pc(csr_pc),
        .csr_cause(csr_cause), .csr_rdata(csr_rdata), .csr_mepc(csr_mepc)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // CSR file model; the only writer of the register variables.
    logic [31:0] mstatus = 0, mtvec = 0, mepc = 0, mcause = 0;
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = 0;
    logic [31:0] poke_val = 0;

    always @(posedge clk) begin
        if (poke_en) begin
            case (poke_addr)
                CSR_MSTATUS: mstatus = poke_val;
                CSR_MTVEC:   mtvec   = poke_val;
                CSR_MEPC:    mepc    = poke_val;
                CSR_MCAUSE:  mcause  = poke_val;
                default: ;
            endcase
        end else if (csr_wen) begin
            case (csr_addr)
                CSR_MSTATUS: mstatus = csr_wdata;
                CSR_MTVEC:   mtvec   = csr_wdata;
                CSR_MEPC:    mepc    = csr_wdata;
                CSR_MCAUSE:  mcause  = csr_wdata;
                default: ;
            endcase
        end else if (csr_unusual) begin
            mepc   = csr_pc;
            mcause = csr_cause;
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        if (csr_unusual) csr_rdata = mtvec;
        else begin
            case (csr_addr)
                CSR_MSTATUS: csr_rdata = mstatus;
                CSR_MTVEC:   csr_rdata = mtvec;
                CSR_MEPC:    csr_rdata = mepc;
                CSR_MCAUSE:  csr_rdata = mcause;
                default:     csr_rdata = 32'h0;
            endcase
        end
    end
    assign csr_mepc = mepc;

    typedef struct packed {
        logic [31:0] cyc;
        logic        ren, wen, unus, rv, dv;
        logic [11:0] addr;
        logic [31:0] wdata, pc, cause, rdata, rpc;
        logic        busy;
    } obs_t;

    typedef struct {
        string name;
        obs_t  v;
    } exp_t;

    exp_t q[$];

    task automatic expect_ev(input string n, input int c,
                             input logic ren, input logic wen, input logic unus,
                             input logic rv, input logic dv, input logic [11:0] a,
                             input logic [31:0] wd, input logic [31:0] pc,
                             input logic [31:0] cause, input logic [31:0] rd,
                             input logic [31:0] rpc);
        exp_t e;
        e.name = n;
        e.v = {c[31:0], ren, wen, unus, rv, dv, a, wd, pc, cause, rd, rpc, 1'b1};
        q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    // Monitor: every strobe cycle must match the next queued event; quiet cycles must be all-zero.
    always @(negedge clk) begin
        obs_t o;
        exp_t e;
        if (mon_en) begin
            o = {cyc[31:0], csr_ren, csr_wen, csr_unusual, resp_valid, redirect_valid,
                 csr_addr, csr_wdata, csr_pc, csr_cause, resp_rdata, redirect_pc, busy};
            checks++;
            if (o.ren | o.wen | o.unus | o.rv | o.dv) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %h expected none", o);
                end else begin
                    e = q.pop_front();
                    if (o !== e.v) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", e.name, o, e.v);
                    end
                end
            end else if ({o.addr, o.wdata, o.pc, o.cause, o.rdata, o.rpc, o.busy} !== '0) begin
                errors++;
                $display("FAIL idle_quiet: got %h expected all-zero outputs at cycle %0d", o, cyc);
            end
        end
    end

    // Called aligned to posedge+1; returns aligned to posedge+1 of the cycle after accept.
    task automatic send(input logic [2:0] op, input logic [11:0] a, input logic [31:0] s,
                        input logic [31:0] pc, output int n);
        req_op = op; req_addr = a; req_src = s; req_pc = pc; req_valid = 1'b1;
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                n = cyc;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no req_ready expected accept within 20 cycles");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] v);
        poke_addr = a; poke_val = v; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic csr_op(input string nm, input logic [2:0] op, input logic [11:0] a,
                          input logic [31:0] s, input logic [31:0] old_v,
                          input logic [31:0] wd, input logic we, output int n);
        send(op, a, s, 32'h0, n);
        expect_ev({nm, "_read"}, n + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, 0, 0, 0, 0, 0);
        expect_ev({nm, "_write"}, n + 2, 1'b0, we, 1'b0, 1'b1, 1'b0, a, we ? wd : 32'h0,
                  0, 0, old_v, 0);
        repeat (3) @(negedge clk);
        chk({nm, "_busy_n3"}, {31'b0, busy}, 32'h0);
        chk({nm, "_ready_n3"}, {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected completion before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m;
        rst = 1'b1; req_valid = 1'b0; req_op = 0; req_addr = 0; req_src = 0; req_pc = 0;
        irq_pending = 1'b0; irq_enable = 1'b0; irq_pc = 0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'b0, req_ready}, 32'h1);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;

        // CSRRW mtvec
        csr_op("rw_mtvec", OP_CSRRW, CSR_MTVEC, 32'h8000_0100, 32'h0, 32'h8000_0100, 1'b1, n);

        // CSRRS set, CSRRS with zero operand, CSRRC
        poke(CSR_MSTATUS, 32'h1800);
        csr_op("rs_set", OP_CSRRS, CSR_MSTATUS, 32'h8, 32'h1800, 32'h1808, 1'b1, n);
        poke(CSR_MSTATUS, 32'h1800);
        csr_op("rs_zero", OP_CSRRS, CSR_MSTATUS, 32'h0, 32'h1800, 32'h0, 1'b0, n);
        poke(CSR_MSTATUS, 32'h1808);
        csr_op("rc_clr", OP_CSRRC, CSR_MSTATUS, 32'h1000, 32'h1808, 32'h0808, 1'b1, n);
        chk("rc_mstatus", mstatus, 32'h0808);

        // ECALL trap entry
        send(OP_ECALL, 12'h0, 32'h0, 32'h8000_0040, n);
        expect_ev("ecall_trap", n + 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h0, 0,
                  32'h8000_0040, 32'd11, 0, 32'h8000_0100);
        repeat (2) @(negedge clk);
        chk("ecall_busy_n2", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;

        // Interrupt beats a simultaneous CSRRW; request held and accepted after trap
        irq_pc = 32'h8000_0200; irq_pending = 1'b1; irq_enable = 1'b1;
        req_op = OP_CSRRW; req_addr = CSR_MEPC; req_src = 32'h55; req_pc = 0; req_valid = 1'b1;
        @(negedge clk);
        chk("irq_blocks_ready", {31'b0, req_ready}, 32'h0);
        m = cyc;
        expect_ev("irq_trap", m + 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h0, 0,
                  32'h8000_0200, 32'h8000_0007, 0, 32'h8000_0100);
        @(posedge clk); #1;
        irq_pending = 1'b0;
        csr_op("held_rw", OP_CSRRW, CSR_MEPC, 32'h55, 32'h8000_0200, 32'h55, 1'b1, n);
        chk("held_accept_cycle", n, m + 2);

        // Masked interrupt is ignored
        irq_pending = 1'b1; irq_enable = 1'b0;
        csr_op("irq_masked", OP_CSRRW, CSR_MCAUSE, 32'h7, 32'h8000_0007, 32'h7, 1'b1, n);
        irq_pending = 1'b0;

        // MRET
        poke(CSR_MEPC, 32'h8000_0044);
        send(OP_MRET, 12'h0, 32'h0, 32'h0, n);
        expect_ev("mret", n + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0, 0, 0, 0, 0,
                  32'h8000_0044);
        repeat (2) @(negedge clk);
        chk("mret_busy_n2", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;

        // Illegal opcode: accepted, no activity
        send(3'd5, CSR_MSTATUS, 32'hFFFF_FFFF, 32'h0, n);
        @(negedge clk);
        chk("illegal_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;

        // Reset during READ aborts the write
        send(OP_CSRRW, CSR_MTVEC, 32'hDEAD_BEEF, 32'h0, n);
        expect_ev("abort_read", n + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CSR_MTVEC, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_ready", {31'b0, req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        chk("abort_mtvec_kept", mtvec, 32'h8000_0100);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
